// File: rtl/pcseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pcseq_pkg
//  Brief    : Shared constants for the next-PC sequencer (state codes, PC
//             width and vectors, drain-window defaults).
//  Revision : 1.0 - initial release
// ============================================================================
package pcseq_pkg;

  localparam int              PC_W      = 16;
  localparam int              PC_INC    = 1;
  localparam int              DRAIN_CYC = 2;
  localparam int              CNT_W     = 4;
  localparam logic [PC_W-1:0] RESET_VEC = 16'h0000;
  localparam logic [PC_W-1:0] TRAP_VEC  = 16'h0010;

  // Encoding is visible on seq_state, so these values are architectural.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

endpackage : pcseq_pkg
`default_nettype wire

// File: rtl/pcseq_drain_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : pcseq_drain_cnt
//  Brief    : 4-bit loadable down-counter timing the post-redirect drain
//             window; saturates at zero, load has priority over enable.
//  Revision : 1.0 - initial release
// ============================================================================
module pcseq_drain_cnt
  import pcseq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);
  assign o_last = (r_cnt == CNT_W'(1));

endmodule : pcseq_drain_cnt
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Brief    : Next-PC controller: sequential/hold/branch/jump/trap select,
//             pipeline flushes and post-redirect fetch drain window.
//             Optional trap support enabled by defining PCSEQ_TRAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int              PC_W      = pcseq_pkg::PC_W,
  parameter int              PC_INC    = pcseq_pkg::PC_INC,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(pcseq_pkg::RESET_VEC),
  parameter int              DRAIN_CYC = pcseq_pkg::DRAIN_CYC,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(pcseq_pkg::TRAP_VEC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            stall_req,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            halt,
  input  logic            resume,
  input  logic            trap_req,
  output logic [PC_W-1:0] pc_next,
  output logic            if_valid,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic [1:0]      seq_state,
  output logic [PC_W-1:0] epc
);

  import pcseq_pkg::*;

  localparam logic [PC_W-1:0]  c_pc_inc   = PC_W'(PC_INC);
  localparam logic [CNT_W-1:0] c_drain_ld = CNT_W'(DRAIN_CYC);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       w_trap;
  logic       w_br;
  logic       w_jmp;
  logic       w_redirect;
  logic       w_cnt_load;
  logic       w_cnt_en;
  logic       w_cnt_zero;
  logic       w_cnt_last;

`ifdef PCSEQ_TRAP_EN
  logic [PC_W-1:0] r_epc;

  assign w_trap = trap_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_epc <= '0;
    end else if (w_trap) begin
      r_epc <= pc_cur;
    end
  end

  assign epc = r_epc;
`else
  logic [PC_W:0] w_unused_trap;

  assign w_trap        = 1'b0;
  assign w_unused_trap = {trap_req, TRAP_VEC};
  assign epc           = '0;
`endif

  // HALT ignores control-flow changes; only a trap can leave it besides resume.
  assign w_br       = br_taken  && (r_state != ST_HALT);
  assign w_jmp      = jmp_valid && (r_state != ST_HALT);
  assign w_redirect = w_trap || w_br || w_jmp;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_en    = 1'b0;
    if (w_redirect) begin
      w_state_nxt = ST_DRAIN;
      w_cnt_load  = 1'b1;
    end else begin
      case (r_state)
        ST_HALT: begin
          if (resume) begin
            w_state_nxt = ST_DRAIN;
            w_cnt_load  = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (halt) begin
            w_state_nxt = ST_HALT;
          end else if (!stall_req) begin
            w_cnt_en = 1'b1;
            if (w_cnt_last || w_cnt_zero) begin
              w_state_nxt = ST_RUN;
            end
          end
        end
        default: begin
          w_state_nxt = halt ? ST_HALT : ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  pcseq_drain_cnt u_drain_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (c_drain_ld),
    .i_en       (w_cnt_en),
    .o_zero     (w_cnt_zero),
    .o_last     (w_cnt_last)
  );

  always_comb begin
    pc_next     = pc_cur + c_pc_inc;
    if_valid    = (r_state == ST_RUN);
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (rst) begin
      pc_next     = RESET_VEC;
      if_valid    = 1'b0;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (w_trap) begin
      pc_next     = TRAP_VEC;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (r_state == ST_HALT) begin
      pc_next = pc_cur;
    end else if (w_br) begin
      pc_next     = br_target;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (w_jmp) begin
      pc_next     = jmp_target;
      flush_if_id = 1'b1;
    end else if (halt || stall_req) begin
      pc_next = pc_cur;
    end
  end

  assign seq_state = r_state;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Brief    : Self-checking bench for pc_sequencer: directed scenarios then
//             randomized traffic against a behavioural next-PC model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

`ifdef PCSEQ_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [15:0] RST_V  = 16'h0000;
  localparam logic [15:0] TRAP_V = 16'h0010;
  localparam int          DRAIN  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_cur;
  logic        stall_req, br_taken, jmp_valid, halt, resume, trap_req;
  logic [15:0] br_target, jmp_target;
  logic [15:0] pc_next, epc;
  logic        if_valid, flush_if_id, flush_id_ex;
  logic [1:0]  seq_state;

  int          n_cmp = 0;
  int          n_bad = 0;

  // Model: mode 0=RUN 1=DRAIN 2=HALT, drain cycles left, saved trap PC.
  int          m_mode  = 0;
  int          m_left  = 0;
  logic [15:0] m_epc   = '0;
  bit          m_known = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .pc_cur      (pc_cur),
    .stall_req   (stall_req),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
    .halt        (halt),
    .resume      (resume),
    .trap_req    (trap_req),
    .pc_next     (pc_next),
    .if_valid    (if_valid),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .seq_state   (seq_state),
    .epc         (epc)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    rst = 1'b0; stall_req = 1'b0; br_taken = 1'b0; jmp_valid = 1'b0;
    halt = 1'b0; resume = 1'b0; trap_req = 1'b0;
  endtask

  // Called just after a rising edge with inputs set; checks, then advances one clock.
  task automatic cycle(input string tag);
    logic [15:0] e_pc, n_epc;
    logic        e_v, e_fi, e_fe;
    int          n_mode, n_left;
    #2;
    n_mode = m_mode; n_left = m_left; n_epc = m_epc;
    e_pc = pc_cur + 16'd1; e_v = (m_mode == 0); e_fi = 1'b0; e_fe = 1'b0;
    if (rst) begin
      e_pc = RST_V; e_v = 1'b0; e_fi = 1'b1; e_fe = 1'b1;
      n_mode = 0; n_left = 0; n_epc = '0;
    end else if (TRAP_EN && trap_req) begin
      e_pc = TRAP_V; e_fi = 1'b1; e_fe = 1'b1;
      n_mode = 1; n_left = DRAIN; n_epc = pc_cur;
    end else if (m_mode == 2) begin
      e_pc = pc_cur;
      if (resume) begin n_mode = 1; n_left = DRAIN; end
    end else if (br_taken) begin
      e_pc = br_target; e_fi = 1'b1; e_fe = 1'b1;
      n_mode = 1; n_left = DRAIN;
    end else if (jmp_valid) begin
      e_pc = jmp_target; e_fi = 1'b1;
      n_mode = 1; n_left = DRAIN;
    end else if (halt) begin
      e_pc = pc_cur; n_mode = 2;
    end else begin
      if (stall_req) e_pc = pc_cur;
      if (m_mode == 1 && !stall_req) begin
        n_left = m_left - 1;
        if (n_left <= 0) begin n_mode = 0; n_left = 0; end
      end
    end
    chk({tag, ".pc_next"},     pc_next,            e_pc);
    chk({tag, ".if_valid"},    16'(if_valid),      16'(e_v));
    chk({tag, ".flush_if_id"}, 16'(flush_if_id),   16'(e_fi));
    chk({tag, ".flush_id_ex"}, 16'(flush_id_ex),   16'(e_fe));
    if (m_known) begin
      chk({tag, ".seq_state"}, 16'(seq_state), 16'(m_mode));
      chk({tag, ".epc"},       epc,            m_epc);
    end
    @(posedge clk);
    #1;
    m_mode = n_mode; m_left = n_left; m_epc = n_epc;
    if (rst) m_known = 1'b1;
    pc_cur = e_pc;
  endtask

  initial begin
    quiet();
    pc_cur = 16'h0000; br_target = '0; jmp_target = '0;

    // Reset then sequential fetch from the reset vector.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t1_rst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle("t1_run");

    // Branch redirect and drain window.
    pc_cur = 16'h0020; br_taken = 1'b1; br_target = 16'h0100;
    cycle("t2_br");
    quiet();
    for (int i = 0; i < 3; i++) cycle("t2_drain");

    // Branch beats jump; jump inside the drain window reloads it.
    pc_cur = 16'h0030; br_taken = 1'b1; br_target = 16'h0100;
    jmp_valid = 1'b1; jmp_target = 16'h0200;
    cycle("t3_br_jmp");
    quiet();
    cycle("t3_drain");
    jmp_valid = 1'b1; jmp_target = 16'h0200;
    cycle("t3_jmp_in_drain");
    quiet();
    for (int i = 0; i < 3; i++) cycle("t3_drain2");

    // Stall freezes PC and drain counter.
    br_taken = 1'b1; br_target = 16'h0040;
    cycle("t4_br");
    quiet();
    stall_req = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t4_stall");
    stall_req = 1'b0;
    for (int i = 0; i < 3; i++) cycle("t4_drain");

    // Halt, ignored branch/jump, resume (with halt also set) then drain.
    pc_cur = 16'h0050; halt = 1'b1;
    cycle("t5_halt");
    quiet();
    for (int i = 0; i < 5; i++) begin
      br_taken = (i == 2); br_target = 16'h0999;
      jmp_valid = (i == 3); jmp_target = 16'h0777;
      stall_req = (i == 4);
      cycle("t5_in_halt");
    end
    quiet();
    halt = 1'b1; resume = 1'b1;
    cycle("t5_resume");
    quiet();
    for (int i = 0; i < 3; i++) cycle("t5_drain");
    halt = 1'b1; resume = 1'b1;
    cycle("t5_halt_in_run");
    quiet();
    resume = 1'b1;
    cycle("t5_resume2");
    quiet();
    for (int i = 0; i < 3; i++) cycle("t5_drain2");

    // Wrap at the top of the address space, then trap (ignored when disabled).
    pc_cur = 16'hFFFF;
    cycle("t6_wrap");
    pc_cur = 16'h1234; trap_req = 1'b1; br_taken = 1'b1; br_target = 16'h0abc;
    cycle("t6_trap");
    quiet();
    for (int i = 0; i < 3; i++) cycle("t6_after");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(63) == 0);
      trap_req   = ($urandom_range(31) == 0);
      br_taken   = ($urandom_range(7) == 0);
      jmp_valid  = ($urandom_range(7) == 0);
      halt       = ($urandom_range(15) == 0);
      resume     = ($urandom_range(3) == 0);
      stall_req  = ($urandom_range(3) == 0);
      br_target  = 16'($urandom);
      jmp_target = 16'($urandom);
      if ($urandom_range(15) == 0) pc_cur = 16'($urandom);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pc_sequencer
`default_nettype wire
